// File: rtl/mips_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// mips_ctrl_pkg
// Shared definitions for the multicycle MIPS main control unit.
//   - state_e   : 4-bit FSM state encodings (FETCH=0 ... ADDIWB=11)
//   - OP_*      : 6-bit opcode constants decoded in DECODE
//   - ALU_*     : ALUOp control classes
//   - ctrl_t    : packed datapath control word produced by ctrl_out_decode
// Build option: CTRL_ADDI_EN enables the addi path (ADDIEX/ADDIWB).
// -----------------------------------------------------------------------------
package mips_ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_RCOMP  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       mem_to_reg;
        logic       ir_write;
        logic       alu_src_a;
        logic       reg_write;
        logic       reg_dst;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic [1:0] alu_src_b;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/ctrl_out_decode.sv
// -----------------------------------------------------------------------------
// ctrl_out_decode
// Combinational Moore output decode: current state -> datapath control word.
// The only input-dependent terms are IRWrite/PCWrite in FETCH, which follow
// mem_ready so the IR and PC update only when the fetch actually completes.
// Ports:
//   state_i     in  4       current FSM state
//   mem_ready_i in  1       memory handshake (used in FETCH only)
//   ctrl_o      out CTRL_W  packed ctrl_t control word
// Build option: CTRL_ADDI_EN adds outputs for ADDIEX/ADDIWB; otherwise those
// encodings decode to all-zero like any other unused state.
// -----------------------------------------------------------------------------
module ctrl_out_decode
    import mips_ctrl_pkg::*;
(
    input  logic [3:0]        state_i,
    input  logic              mem_ready_i,
    output logic [CTRL_W-1:0] ctrl_o
);

    ctrl_t ctrl_next;

    always_comb begin
        ctrl_next = '0;
        case (state_i)
            S_FETCH: begin
                ctrl_next.mem_read  = 1'b1;
                ctrl_next.alu_src_b = 2'b01;
                ctrl_next.alu_op    = ALU_ADD;
                ctrl_next.ir_write  = mem_ready_i;
                ctrl_next.pc_write  = mem_ready_i;
            end
            S_DECODE: begin
                ctrl_next.alu_src_b = 2'b11;
                ctrl_next.alu_op    = ALU_ADD;
            end
            S_MEMADR: begin
                ctrl_next.alu_src_a = 1'b1;
                ctrl_next.alu_src_b = 2'b10;
                ctrl_next.alu_op    = ALU_ADD;
            end
            S_MEMRD: begin
                ctrl_next.mem_read = 1'b1;
                ctrl_next.iord     = 1'b1;
            end
            S_MEMWB: begin
                ctrl_next.reg_write  = 1'b1;
                ctrl_next.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                ctrl_next.mem_write = 1'b1;
                ctrl_next.iord      = 1'b1;
            end
            S_EXEC: begin
                ctrl_next.alu_src_a = 1'b1;
                ctrl_next.alu_op    = ALU_FUNCT;
            end
            S_RCOMP: begin
                ctrl_next.reg_write = 1'b1;
                ctrl_next.reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                ctrl_next.alu_src_a     = 1'b1;
                ctrl_next.alu_op        = ALU_SUB;
                ctrl_next.pc_write_cond = 1'b1;
                ctrl_next.pc_source     = 2'b01;
            end
            S_JUMP: begin
                ctrl_next.pc_write  = 1'b1;
                ctrl_next.pc_source = 2'b10;
            end
`ifdef CTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl_next.alu_src_a = 1'b1;
                ctrl_next.alu_src_b = 2'b10;
                ctrl_next.alu_op    = ALU_ADD;
            end
            S_ADDIWB: begin
                ctrl_next.reg_write = 1'b1;
            end
`else
            // Without addi, encodings 10/11 fall through to the all-zero default.
`endif
            default: ;
        endcase
    end

    assign ctrl_o = ctrl_next;

endmodule

// File: rtl/control_multiciclo.sv
// -----------------------------------------------------------------------------
// control_multiciclo
// Multicycle MIPS main control FSM (fetch/decode/execute/memory/write-back).
// Holds the state register and next-state logic; output decode lives in
// ctrl_out_decode. Memory stages (FETCH, MEMRD, MEMWR) stall on mem_ready.
// Ports:
//   clk                       in  1   rising-edge clock
//   rst_n                     in  1   synchronous active-low reset; while low
//                                     every output (incl. state) reads 0
//   Op                        in  6   opcode, sampled only in DECODE
//   mem_ready                 in  1   memory access completes this cycle
//   PCWrite .. RegDst         out 1   datapath controls
//   PCSource, ALUOp, ALUSrcB  out 2   mux selects / ALU class
//   state                     out 4   current state encoding
//   illegal_op                out 1   high during DECODE of unsupported opcode
// Build option: CTRL_ADDI_EN decodes opcode 001000 (addi) via ADDIEX/ADDIWB;
// without it addi is reported as illegal.
// -----------------------------------------------------------------------------
module control_multiciclo
    import mips_ctrl_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] Op,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            MemtoReg,
    output logic            IRWrite,
    output logic            ALUSrcA,
    output logic            RegWrite,
    output logic            RegDst,
    output logic [1:0]      PCSource,
    output logic [1:0]      ALUOp,
    output logic [1:0]      ALUSrcB,
    output logic [3:0]      state,
    output logic            illegal_op
);

    state_e state_q, state_d;
    // Op is only valid in DECODE, so the lw/sw choice is remembered for MEMADR.
    logic   is_sw_q, is_sw_d;
    logic   illegal_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            is_sw_q <= 1'b0;
        end else begin
            state_q <= state_d;
            is_sw_q <= is_sw_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        is_sw_d   = is_sw_q;
        illegal_d = 1'b0;
        case (state_q)
            S_FETCH:  if (mem_ready) state_d = S_DECODE;
            S_DECODE: begin
                state_d = S_FETCH;
                is_sw_d = (Op == OP_SW);
                case (Op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`endif
                    default:      illegal_d = 1'b1;
                endcase
            end
            S_MEMADR: state_d = is_sw_q ? S_MEMWR : S_MEMRD;
            S_MEMRD:  if (mem_ready) state_d = S_MEMWB;
            S_MEMWB:  state_d = S_FETCH;
            S_MEMWR:  if (mem_ready) state_d = S_FETCH;
            S_EXEC:   state_d = S_RCOMP;
            S_RCOMP:  state_d = S_FETCH;
            S_BRANCH: state_d = S_FETCH;
            S_JUMP:   state_d = S_FETCH;
`ifdef CTRL_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
            S_ADDIWB: state_d = S_FETCH;
`else
            // ADDIEX/ADDIWB are unused encodings here and recover via default.
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    logic [CTRL_W-1:0] ctrl_raw;
    ctrl_t             ctrl_gated;

    ctrl_out_decode u_out_decode (
        .state_i     (state_q),
        .mem_ready_i (mem_ready),
        .ctrl_o      (ctrl_raw)
    );

    // Reset overrides the decode combinationally so a write-back in flight
    // cannot reach the register bank during the cycle reset is asserted.
    assign ctrl_gated = rst_n ? ctrl_t'(ctrl_raw) : '0;

    assign PCWrite     = ctrl_gated.pc_write;
    assign PCWriteCond = ctrl_gated.pc_write_cond;
    assign IorD        = ctrl_gated.iord;
    assign MemRead     = ctrl_gated.mem_read;
    assign MemWrite    = ctrl_gated.mem_write;
    assign MemtoReg    = ctrl_gated.mem_to_reg;
    assign IRWrite     = ctrl_gated.ir_write;
    assign ALUSrcA     = ctrl_gated.alu_src_a;
    assign RegWrite    = ctrl_gated.reg_write;
    assign RegDst      = ctrl_gated.reg_dst;
    assign PCSource    = ctrl_gated.pc_source;
    assign ALUOp       = ctrl_gated.alu_op;
    assign ALUSrcB     = ctrl_gated.alu_src_b;
    assign state       = rst_n ? state_q : 4'd0;
    assign illegal_op  = rst_n & illegal_d;

endmodule

// File: tb/tb_control_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_control_multiciclo
// Self-checking bench for control_multiciclo. A reference model plans each
// instruction as a list of states from its opcode, holds memory stages while
// mem_ready is low, and derives expected outputs from a per-state table.
// Observation vector layout (21 bits):
//   [20:17] state, [16] PCWrite, [15] PCWriteCond, [14] IorD, [13] MemRead,
//   [12] MemWrite, [11] MemtoReg, [10] IRWrite, [9] ALUSrcA, [8] RegWrite,
//   [7] RegDst, [6:5] PCSource, [4:3] ALUOp, [2:1] ALUSrcB, [0] illegal_op
// Honours CTRL_ADDI_EN the same way as the design.
// -----------------------------------------------------------------------------
module tb_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] Op;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg;
    logic       IRWrite, ALUSrcA, RegWrite, RegDst;
    logic [1:0] PCSource, ALUOp, ALUSrcB;
    logic [3:0] state;
    logic       illegal_op;

    int n_checks = 0;
    int n_fail   = 0;

    localparam int B_MEMWRITE = 12;
    localparam int B_REGWRITE = 8;

    int          path_q[$];
    logic [20:0] obs_q[$];
    logic [20:0] exp_q[$];
    bit          mr_plan[$];

    always #5 clk = ~clk;

    control_multiciclo #(.OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
        .IRWrite(IRWrite), .ALUSrcA(ALUSrcA), .RegWrite(RegWrite),
        .RegDst(RegDst), .PCSource(PCSource), .ALUOp(ALUOp),
        .ALUSrcB(ALUSrcB), .state(state), .illegal_op(illegal_op)
    );

    function automatic bit addi_enabled();
`ifdef CTRL_ADDI_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic bit op_legal(input logic [5:0] op);
        return (op == 6'b100011) || (op == 6'b101011) || (op == 6'b000000) ||
               (op == 6'b000100) || (op == 6'b000010) ||
               (addi_enabled() && op == 6'b001000);
    endfunction

    // Expected outputs straight from the per-state table.
    function automatic logic [20:0] exp_vec(input int st, input bit mr, input logic [5:0] op);
        logic [3:0] s;
        logic pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill;
        logic [1:0] pcs, aop, asb;
        s = 4'(st);
        {pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, ill} = '0;
        pcs = 2'b00; aop = 2'b00; asb = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  begin asb = 2'b11; ill = !op_legal(op); end
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iord = 1; end
            4:  begin rw = 1; m2r = 1; end
            5:  begin mwr = 1; iord = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rw = 1; rd = 1; end
            8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: begin rw = 1; end
            default: ;
        endcase
        return {s, pcw, pcwc, iord, mrd, mwr, m2r, irw, asa, rw, rd, pcs, aop, asb, ill};
    endfunction

    function automatic logic [20:0] sample();
        return {state, PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUOp, ALUSrcB, illegal_op};
    endfunction

    task automatic plan(input logic [5:0] op);
        path_q.delete();
        path_q.push_back(0);
        path_q.push_back(1);
        if (op == 6'b100011) begin path_q.push_back(2); path_q.push_back(3); path_q.push_back(4); end
        else if (op == 6'b101011) begin path_q.push_back(2); path_q.push_back(5); end
        else if (op == 6'b000000) begin path_q.push_back(6); path_q.push_back(7); end
        else if (op == 6'b000100) path_q.push_back(8);
        else if (op == 6'b000010) path_q.push_back(9);
        else if (op == 6'b001000 && addi_enabled()) begin path_q.push_back(10); path_q.push_back(11); end
    endtask

    // Runs one instruction starting just after a rising edge with the DUT in
    // FETCH; records observed and expected vectors for every cycle. Never
    // waits on the DUT, so it always terminates.
    task automatic exec_instr(input logic [5:0] op, input bit rand_mr);
        int idx;
        int st;
        bit mr;
        plan(op);
        obs_q.delete();
        exp_q.delete();
        idx = 0;
        while (idx < path_q.size()) begin
            st = path_q[idx];
            if (rand_mr) mr = ($urandom_range(0, 3) != 0);
            else if (mr_plan.size() > 0) mr = mr_plan.pop_front();
            else mr = 1'b1;
            mem_ready = mr;
            Op = (st == 1) ? op : 6'($urandom);
            @(negedge clk);
            obs_q.push_back(sample());
            exp_q.push_back(exp_vec(st, mr, op));
            if (!(st == 0 || st == 3 || st == 5) || mr) idx++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        logic [20:0] obs;
        logic [20:0] exp;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        Op = 6'b100011;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            obs = sample();
            n_checks++;
            if (obs !== 21'd0) begin
                n_fail++;
                $display("FAIL reset_hold cycle %0d: got %h expected %h", i, obs, 21'd0);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        obs = sample();
        exp = exp_vec(0, 1'b1, 6'd0);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL reset_release: got %h expected %h", obs, exp);
        end
        // Pull reset once more so the DUT is parked in FETCH for the next test.
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_lw();
        int rw_cycles = 0;
        exec_instr(6'b100011, 1'b0);
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL lw cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][B_REGWRITE]) rw_cycles++;
        end
        n_checks++;
        if (rw_cycles !== 1) begin
            n_fail++;
            $display("FAIL lw_regwrite_cycles: got %0d expected 1", rw_cycles);
        end
        $display("test_lw: %0d cycles", obs_q.size());
    endtask

    task automatic test_sw_stall();
        int mw_cycles = 0;
        int rw_cycles = 0;
        mr_plan.delete();
        // FETCH ready, DECODE/MEMADR ignore mem_ready, then 3 stall cycles.
        mr_plan = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        exec_instr(6'b101011, 1'b0);
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL sw_stall cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
            if (obs_q[i][B_MEMWRITE]) mw_cycles++;
            if (obs_q[i][B_REGWRITE]) rw_cycles++;
        end
        n_checks++;
        if (mw_cycles !== 4 || rw_cycles !== 0) begin
            n_fail++;
            $display("FAIL sw_counts: got memwrite=%0d regwrite=%0d expected 4 and 0", mw_cycles, rw_cycles);
        end
        $display("test_sw_stall: %0d cycles", obs_q.size());
    endtask

    task automatic test_fetch_stall();
        mr_plan.delete();
        mr_plan = '{1'b0, 1'b0, 1'b1};
        exec_instr(6'b000000, 1'b0);
        foreach (obs_q[i]) begin
            n_checks++;
            if (obs_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL fetch_stall cycle %0d: got %h expected %h", i, obs_q[i], exp_q[i]);
            end
        end
        $display("test_fetch_stall: %0d cycles", obs_q.size());
    endtask

    task automatic test_rtype_branch_jump();
        logic [5:0] ops [3];
        ops[0] = 6'b000000;
        ops[1] = 6'b000100;
        ops[2] = 6'b000010;
        for (int k = 0; k < 3; k++) begin
            exec_instr(ops[k], 1'b0);
            foreach (obs_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL op%b cycle %0d: got %h expected %h", ops[k], i, obs_q[i], exp_q[i]);
                end
            end
            $display("test_rtype_branch_jump: op %b %0d cycles", ops[k], obs_q.size());
        end
    endtask

    task automatic test_addi_illegal();
        logic [5:0] ops [3];
        ops[0] = 6'b001000;
        ops[1] = 6'b111111;
        ops[2] = 6'b000001;
        for (int k = 0; k < 3; k++) begin
            exec_instr(ops[k], 1'b0);
            foreach (obs_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL addi_illegal op%b cycle %0d: got %h expected %h", ops[k], i, obs_q[i], exp_q[i]);
                end
            end
            $display("test_addi_illegal: op %b %0d cycles", ops[k], obs_q.size());
        end
    endtask

    task automatic test_reset_in_memwb();
        logic [20:0] obs;
        logic [20:0] exp;
        int exp_states [4] = '{0, 1, 2, 3};
        mem_ready = 1'b1;
        Op = 6'b100011;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if (state !== 4'(exp_states[i])) begin
                n_fail++;
                $display("FAIL memwb_approach cycle %0d: got state %0d expected %0d", i, state, exp_states[i]);
            end
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        @(negedge clk);
        obs = sample();
        n_checks++;
        if (obs !== 21'd0) begin
            n_fail++;
            $display("FAIL memwb_reset: got %h expected %h", obs, 21'd0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        @(negedge clk);
        obs = sample();
        exp = exp_vec(0, 1'b0, 6'd0);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL memwb_after_reset: got %h expected %h", obs, exp);
        end
        @(posedge clk);
        #1;
        $display("test_reset_in_memwb done");
    endtask

    task automatic test_random();
        logic [5:0] op;
        int k;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 6);
            case (k)
                0: op = 6'b100011;
                1: op = 6'b101011;
                2: op = 6'b000000;
                3: op = 6'b000100;
                4: op = 6'b000010;
                5: op = 6'b001000;
                default: begin
                    op = 6'($urandom);
                    while (op_legal(op) || op == 6'b001000) op = 6'($urandom);
                end
            endcase
            exec_instr(op, 1'b1);
            foreach (obs_q[i]) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL random#%0d op%b cycle %0d: got %h expected %h", n, op, i, obs_q[i], exp_q[i]);
                end
            end
            $display("test_random #%0d: op %b %0d cycles", n, op, obs_q.size());
        end
    endtask

    initial begin
        rst_n = 1'b0;
        mem_ready = 1'b0;
        Op = 6'd0;
        test_reset();
        test_lw();
        test_sw_stall();
        test_fetch_stall();
        test_rtype_branch_jump();
        test_addi_illegal();
        test_reset_in_memwb();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
